// File: rtl/dm_arbiter_if.sv
// Signal bundle between M-stage control, the debug/loader requester and the data memory.
// The arbiter uses the slave view; requesters and the memory use the master view.
interface dm_arbiter_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [1:0]  cpu_op;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_pc;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;

    logic        dbg_req;
    logic        dbg_we;
    logic [1:0]  dbg_op;
    logic [31:0] dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_ack;
    logic [31:0] dbg_rdata;
    logic        dbg_rvalid;

    logic        dm_we;
    logic [1:0]  dm_op;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_wpc;
    logic [31:0] dm_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_op, cpu_addr, cpu_wdata, cpu_pc,
        output cpu_rdata, cpu_stall,
        input  dbg_req, dbg_we, dbg_op, dbg_addr, dbg_wdata,
        output dbg_ack, dbg_rdata, dbg_rvalid,
        output dm_we, dm_op, dm_addr, dm_wdata, dm_wpc,
        input  dm_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_op, cpu_addr, cpu_wdata, cpu_pc,
        input  cpu_rdata, cpu_stall,
        output dbg_req, dbg_we, dbg_op, dbg_addr, dbg_wdata,
        input  dbg_ack, dbg_rdata, dbg_rvalid,
        input  dm_we, dm_op, dm_addr, dm_wdata, dm_wpc,
        output dm_rdata
    );
endinterface

// File: rtl/dm_arbiter.sv
// Shares the M-stage data-memory port between the CPU (zero-latency owner) and a
// debug/loader requester that is served in idle CPU cycles or force-granted after a bounded wait.
module dm_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    dm_arbiter_if.slave   bus
);

    typedef enum logic {
        ARB,
        RESP
    } state_e;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_e      state_q, state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0] dbg_rdata_q, dbg_rdata_d;
    logic        dbg_rvalid_q, dbg_rvalid_d;
    logic        grant_dbg;

    // RESP blocks DBG so a force-grant can never stall the CPU two cycles in a row.
    assign grant_dbg = (state_q == ARB) && bus.dbg_req &&
                       (!bus.cpu_req || (wait_cnt_q == LIMIT));

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        bus.dm_we    = bus.cpu_req & bus.cpu_we;
        bus.dm_op    = bus.cpu_op;
        bus.dm_addr  = bus.cpu_addr;
        bus.dm_wdata = bus.cpu_wdata;
        bus.dm_wpc   = bus.cpu_pc;
        if (grant_dbg) begin
            bus.dm_we    = bus.dbg_we;
            bus.dm_op    = bus.dbg_op;
            bus.dm_addr  = bus.dbg_addr;
            bus.dm_wdata = bus.dbg_wdata;
            bus.dm_wpc   = 32'h0000_0000;
        end
    end

    assign bus.cpu_rdata  = bus.dm_rdata;
    assign bus.cpu_stall  = bus.cpu_req & grant_dbg;
    assign bus.dbg_ack    = grant_dbg;
    assign bus.dbg_rdata  = dbg_rdata_q;
    assign bus.dbg_rvalid = dbg_rvalid_q;

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        dbg_rdata_d  = dbg_rdata_q;
        dbg_rvalid_d = 1'b0;
        unique case (state_q)
            ARB: begin
                if (grant_dbg) begin
                    // Stores capture too: DBG sees the pre-write word and still gets rvalid.
                    dbg_rdata_d  = bus.dm_rdata;
                    dbg_rvalid_d = 1'b1;
                    wait_cnt_d   = 4'd0;
                    state_d      = RESP;
                end else if (bus.dbg_req && (wait_cnt_q != LIMIT)) begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            RESP: begin
                state_d = ARB;
            end
            default: begin
                state_d = ARB;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            state_q      <= ARB;
            wait_cnt_q   <= 4'd0;
            dbg_rdata_q  <= 32'h0000_0000;
            dbg_rvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            dbg_rdata_q  <= dbg_rdata_d;
            dbg_rvalid_q <= dbg_rvalid_d;
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a small data-memory model and a DBG read-data scoreboard.
module tb_dm_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mem [0:15];

    always #5 clk = ~clk;

    dm_arbiter_if bus ();

    dm_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Memory model: combinational, size/sign-adjusted read; byte-lane writes on the clock.
    always_comb begin
        logic [31:0] w;
        w = mem[bus.dm_addr[5:2]];
        case (bus.dm_op)
            2'b01:   bus.dm_rdata = {{24{w[8*bus.dm_addr[1:0]+7]}}, w[8*bus.dm_addr[1:0] +: 8]};
            2'b10:   bus.dm_rdata = {{16{w[16*bus.dm_addr[1]+15]}}, w[16*bus.dm_addr[1] +: 16]};
            default: bus.dm_rdata = w;
        endcase
    end

    always @(posedge clk) begin
        if (!reset && bus.dm_we) begin
            case (bus.dm_op)
                2'b01:   mem[bus.dm_addr[5:2]][8*bus.dm_addr[1:0] +: 8] <= bus.dm_wdata[7:0];
                2'b10:   mem[bus.dm_addr[5:2]][16*bus.dm_addr[1] +: 16] <= bus.dm_wdata[15:0];
                default: mem[bus.dm_addr[5:2]] <= bus.dm_wdata;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Checks dbg_rvalid and, when it is high, pops the scoreboard for dbg_rdata.
    task automatic check_rvalid(input string tag, input logic exp_valid);
        check({tag, "_rvalid"}, {31'd0, bus.dbg_rvalid}, {31'd0, exp_valid});
        if (bus.dbg_rvalid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check({tag, "_sb_empty"}, bus.dbg_rdata, 32'hxxxx_xxxx);
            end else begin
                check({tag, "_rdata"}, bus.dbg_rdata, exp_q.pop_front());
            end
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic cpu_drive(input logic req, input logic we, input logic [1:0] op,
                             input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] pc);
        bus.cpu_req = req; bus.cpu_we = we; bus.cpu_op = op;
        bus.cpu_addr = addr; bus.cpu_wdata = wdata; bus.cpu_pc = pc;
    endtask

    task automatic dbg_drive(input logic req, input logic we, input logic [1:0] op,
                             input logic [31:0] addr, input logic [31:0] wdata);
        bus.dbg_req = req; bus.dbg_we = we; bus.dbg_op = op;
        bus.dbg_addr = addr; bus.dbg_wdata = wdata;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0000_0000;
        cpu_drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
        dbg_drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);

        // Reset state
        repeat (2) next_cycle();
        reset = 1'b0;
        sample();
        check("rst_rvalid", {31'd0, bus.dbg_rvalid}, 32'd0);
        check("rst_rdata", bus.dbg_rdata, 32'h0);
        check("rst_wait_cnt", {28'd0, dut.wait_cnt_q}, 32'd0);
        check("rst_ack", {31'd0, bus.dbg_ack}, 32'd0);

        // CPU word store, no DBG traffic
        next_cycle();
        cpu_drive(1'b1, 1'b1, 2'b00, 32'h10, 32'h1234_5678, 32'h0000_0100);
        sample();
        check("cst_we", {31'd0, bus.dm_we}, 32'd1);
        check("cst_wpc", bus.dm_wpc, 32'h0000_0100);
        check("cst_addr", bus.dm_addr, 32'h10);
        check("cst_wdata", bus.dm_wdata, 32'h1234_5678);
        check("cst_stall", {31'd0, bus.cpu_stall}, 32'd0);

        // CPU load returns stored word
        next_cycle();
        cpu_drive(1'b1, 1'b0, 2'b00, 32'h10, 32'h0, 32'h0000_0104);
        sample();
        check("cld_rdata", bus.cpu_rdata, 32'h1234_5678);
        check("cld_we", {31'd0, bus.dm_we}, 32'd0);

        // DBG read while CPU idle
        next_cycle();
        cpu_drive(1'b0, 1'b1, 2'b00, 32'h20, 32'hdead_beef, 32'h0000_0108);
        dbg_drive(1'b1, 1'b0, 2'b00, 32'h10, 32'h0);
        exp_q.push_back(32'h1234_5678);
        sample();
        check("drd_ack", {31'd0, bus.dbg_ack}, 32'd1);
        check("drd_we", {31'd0, bus.dm_we}, 32'd0);
        check("drd_wpc", bus.dm_wpc, 32'h0);
        check("drd_addr", bus.dm_addr, 32'h10);
        next_cycle();
        dbg_drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        sample();
        check_rvalid("drd_resp", 1'b1);
        check("drd_resp_ack", {31'd0, bus.dbg_ack}, 32'd0);
        next_cycle();
        sample();
        check_rvalid("drd_after", 1'b0);

        // Starvation: continuous CPU loads, DBG held; force-grant on the fifth cycle
        next_cycle();
        cpu_drive(1'b1, 1'b0, 2'b00, 32'h10, 32'h0, 32'h0000_0200);
        dbg_drive(1'b1, 1'b0, 2'b00, 32'h14, 32'h0);
        for (int i = 0; i < 4; i++) begin
            sample();
            check($sformatf("stv_wait%0d", i), {28'd0, dut.wait_cnt_q}, 32'(i));
            check($sformatf("stv_ack%0d", i), {31'd0, bus.dbg_ack}, 32'd0);
            check($sformatf("stv_stall%0d", i), {31'd0, bus.cpu_stall}, 32'd0);
            check($sformatf("stv_addr%0d", i), bus.dm_addr, 32'h10);
            next_cycle();
        end
        exp_q.push_back(32'h0000_0000);
        sample();
        check("stv_grant_ack", {31'd0, bus.dbg_ack}, 32'd1);
        check("stv_grant_stall", {31'd0, bus.cpu_stall}, 32'd1);
        check("stv_grant_addr", bus.dm_addr, 32'h14);
        check("stv_grant_wpc", bus.dm_wpc, 32'h0);
        next_cycle();
        dbg_drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        sample();
        check("stv_resp_stall", {31'd0, bus.cpu_stall}, 32'd0);
        check("stv_resp_wait", {28'd0, dut.wait_cnt_q}, 32'd0);
        check("stv_resp_wpc", bus.dm_wpc, 32'h0000_0200);
        check_rvalid("stv_resp", 1'b1);

        // DBG byte store 0xAB to 0x11; captured data is the pre-write sign-adjusted byte 0x56
        next_cycle();
        cpu_drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
        dbg_drive(1'b1, 1'b1, 2'b01, 32'h11, 32'h0000_00ab);
        exp_q.push_back(32'h0000_0056);
        sample();
        check("dst_ack", {31'd0, bus.dbg_ack}, 32'd1);
        check("dst_we", {31'd0, bus.dm_we}, 32'd1);
        check("dst_op", {30'd0, bus.dm_op}, 32'd1);
        check("dst_wpc", bus.dm_wpc, 32'h0);
        next_cycle();
        dbg_drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        sample();
        check_rvalid("dst_resp", 1'b1);
        next_cycle();
        cpu_drive(1'b1, 1'b0, 2'b00, 32'h10, 32'h0, 32'h0000_0300);
        sample();
        check("dst_cpu_load", bus.cpu_rdata, 32'h1234_ab78);

        // dbg_req held across two transactions: acks on N and N+2, not N+1; op 11 passes through
        next_cycle();
        cpu_drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
        dbg_drive(1'b1, 1'b0, 2'b11, 32'h10, 32'h0);
        exp_q.push_back(32'h1234_ab78);
        sample();
        check("b2b_ack_n", {31'd0, bus.dbg_ack}, 32'd1);
        check("b2b_op", {30'd0, bus.dm_op}, 32'd3);
        next_cycle();
        sample();
        check("b2b_ack_n1", {31'd0, bus.dbg_ack}, 32'd0);
        check_rvalid("b2b_n1", 1'b1);
        next_cycle();
        exp_q.push_back(32'h1234_ab78);
        sample();
        check("b2b_ack_n2", {31'd0, bus.dbg_ack}, 32'd1);
        check_rvalid("b2b_n2", 1'b0);
        next_cycle();
        dbg_drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        sample();
        check_rvalid("b2b_n3", 1'b1);

        // Reset in ARB clears a non-zero wait_cnt
        next_cycle();
        cpu_drive(1'b1, 1'b0, 2'b00, 32'h10, 32'h0, 32'h0000_0400);
        dbg_drive(1'b1, 1'b0, 2'b00, 32'h10, 32'h0);
        next_cycle();
        next_cycle();
        sample();
        check("rarb_wait_pre", {28'd0, dut.wait_cnt_q}, 32'd2);
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        cpu_drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
        dbg_drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        sample();
        check("rarb_wait", {28'd0, dut.wait_cnt_q}, 32'd0);

        // Reset pulsed in RESP: rvalid drops, block back in ARB and grants at once
        next_cycle();
        dbg_drive(1'b1, 1'b0, 2'b00, 32'h10, 32'h0);
        exp_q.push_back(32'h1234_ab78);
        sample();
        check("rrsp_ack", {31'd0, bus.dbg_ack}, 32'd1);
        next_cycle();
        dbg_drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        reset = 1'b1;
        sample();
        check_rvalid("rrsp_resp", 1'b1);
        next_cycle();
        reset = 1'b0;
        sample();
        check_rvalid("rrsp_after", 1'b0);
        check("rrsp_wait", {28'd0, dut.wait_cnt_q}, 32'd0);
        next_cycle();
        dbg_drive(1'b1, 1'b0, 2'b00, 32'h10, 32'h0);
        exp_q.push_back(32'h1234_ab78);
        sample();
        check("rrsp_arb_ack", {31'd0, bus.dbg_ack}, 32'd1);
        next_cycle();
        dbg_drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        sample();
        check_rvalid("rrsp_reissue", 1'b1);

        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
